core_clock_ctrl: RTL and testbench

- Sequences the CPU core clock and core reset from the 50 MHz board clock.
- Replaces the ad-hoc clock/reset glue at top level with one controller that provides:
  - power-on reset stretching;
  - a reset path for the reset key and for software reset requests;
  - a free-running divided clock;
  - debounced manual single-step;
  - a sticky breakpoint halt.
- Sits between the board inputs (SW, KEY) and the cpu instance. The cpu's clkbreak and rstReq feed back into this block.

---
 rtl/core_clock_ctrl_if.sv | 11 +
 rtl/core_clock_ctrl.sv | 125 ++++++++++++
 tb/tb_core_clock_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/core_clock_ctrl_if.sv
// core_clock_ctrl_if: cpu-side bundle of core_clock_ctrl (reset request, breakpoint, core clock/reset, status)
interface core_clock_ctrl_if;
    logic        rst_req;
    logic        clkbreak;
    logic        core_clock;
    logic        core_rst;
    logic        halted;
    logic [31:0] cycle_count;
    modport master (input rst_req, clkbreak, output core_clock, core_rst, halted, cycle_count);
    modport slave (output rst_req, clkbreak, input core_clock, core_rst, halted, cycle_count);
endinterface

// File: rtl/core_clock_ctrl.sv
// core_clock_ctrl: core clock/reset sequencer (reset stretch, run/halt/step, breakpoint); cycle counter via CORE_CLOCK_CTRL_CYCLE_COUNT_EN
module core_clock_ctrl #(
    parameter int DIV_LOG2        = 1,
    parameter int PWR_RST_BITS    = 25,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk50,
    input  logic rst_n,
    input  logic run_sw,
    input  logic step_key_n,
    input  logic key_rst_n,
    core_clock_ctrl_if.master bus
);
    typedef enum logic [2:0] {RESET, RUN, HALT, STEP_HI, STEP_LO} state_t;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DEB_ONE = DW'(1);
    localparam logic [PWR_RST_BITS:0] RST_ONE = (PWR_RST_BITS + 1)'(1);
    localparam logic [DIV_LOG2-1:0] PRE_ONE = DIV_LOG2'(1);
    state_t state_q, state_d;
    logic [1:0] run_sync_q, run_sync_d, step_sync_q, step_sync_d, key_sync_q, key_sync_d;
    logic run_prev_q, run_prev_d, step_prev_q, step_prev_d, db_q, db_d, first_q, first_d;
    logic brk_q, brk_d, core_clock_q, core_clock_d, core_rst_q, core_rst_d, halted;
    logic [DW-1:0] stab_q, stab_d;
    logic [PWR_RST_BITS:0] rst_cnt_q, rst_cnt_d;
    logic [DIV_LOG2-1:0] presc_q, presc_d;
    logic step_chg, step_pulse, run_rise, rst_clr, tc, halt_exit;
    assign step_chg   = step_sync_q[1] != step_prev_q;
    assign step_pulse = db_q & ~db_d;
    assign run_rise   = run_sync_q[1] & ~run_prev_q;
    assign rst_clr    = ~key_sync_q[1] | bus.rst_req | first_q;
    assign tc         = &presc_q;
    assign halt_exit  = state_q == HALT && state_d != HALT;
    // synchronizers, step debounce and reset stretch counter
    always_comb begin
        run_sync_d  = {run_sync_q[0], run_sw};
        step_sync_d = {step_sync_q[0], step_key_n};
        key_sync_d  = {key_sync_q[0], key_rst_n};
        run_prev_d  = run_sync_q[1];
        step_prev_d = step_sync_q[1];
        stab_d      = step_chg ? '0 : (stab_q == DEB_LAST) ? stab_q : stab_q + DEB_ONE;
        db_d        = (!step_chg && stab_q == DEB_LAST) ? step_prev_q : db_q;
        first_d     = 1'b0;
        rst_cnt_d   = rst_clr ? '0 : rst_cnt_q[PWR_RST_BITS] ? rst_cnt_q : rst_cnt_q + RST_ONE;
        core_rst_d  = ~rst_cnt_d[PWR_RST_BITS];
    end
    // breakpoint latch: ignored in reset, held until HALT is left
    always_comb begin
        brk_d = (core_rst_q || halt_exit) ? 1'b0 : brk_q | bus.clkbreak;
    end
    // datapath registers
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            run_sync_q   <= 2'b00;
            step_sync_q  <= 2'b11;
            key_sync_q   <= 2'b11;
            run_prev_q   <= 1'b0;
            step_prev_q  <= 1'b1;
            stab_q       <= '0;
            db_q         <= 1'b1;
            first_q      <= 1'b1;
            rst_cnt_q    <= '0;
            core_rst_q   <= 1'b1;
            brk_q        <= 1'b0;
            core_clock_q <= 1'b0;
            presc_q      <= '0;
        end else begin
            run_sync_q   <= run_sync_d;
            step_sync_q  <= step_sync_d;
            key_sync_q   <= key_sync_d;
            run_prev_q   <= run_prev_d;
            step_prev_q  <= step_prev_d;
            stab_q       <= stab_d;
            db_q         <= db_d;
            first_q      <= first_d;
            rst_cnt_q    <= rst_cnt_d;
            core_rst_q   <= core_rst_d;
            brk_q        <= brk_d;
            core_clock_q <= core_clock_d;
            presc_q      <= presc_d;
        end
    end
    // FSM state register
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) state_q <= RESET;
        else state_q <= state_d;
    end
    // FSM next state: reset wins, clock only stops at a would-be rising edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   if (!core_rst_q) state_d = run_sync_q[1] ? RUN : HALT;
            RUN:     if (tc && !core_clock_q && (brk_q || bus.clkbreak || !run_sync_q[1])) state_d = HALT;
            HALT:    state_d = step_pulse ? STEP_HI : run_rise ? RUN : HALT;
            STEP_HI: if (tc) state_d = STEP_LO;
            STEP_LO: if (tc) state_d = HALT;
            default: state_d = RESET;
        endcase
        if (core_rst_d) state_d = RESET;
    end
    // FSM outputs: prescaler restarts on every state change, core clock follows the state
    always_comb begin
        presc_d      = (state_d != state_q || !(state_q inside {RUN, STEP_HI, STEP_LO})) ? '0 : presc_q + PRE_ONE;
        core_clock_d = (state_d == STEP_HI) ? 1'b1 : (state_d == RUN && state_q == RUN) ? core_clock_q ^ tc : 1'b0;
        halted       = state_q == HALT;
    end
    assign bus.core_clock = core_clock_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.halted     = halted;
`ifdef CORE_CLOCK_CTRL_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;
    // core clock rising-edge counter, cleared by core reset
    always_comb begin
        cyc_d = core_rst_d ? 32'h0 : (core_clock_d & ~core_clock_q) ? cyc_q + 32'h1 : cyc_q;
    end
    // cycle counter register
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) cyc_q <= 32'h0;
        else cyc_q <= cyc_d;
    end
    assign bus.cycle_count = cyc_q;
`else
    assign bus.cycle_count = 32'h0;
`endif
endmodule

// File: tb/tb_core_clock_ctrl.sv
// tb_core_clock_ctrl: randomized self-checking bench for core_clock_ctrl against an edge-counting reference
module tb_core_clock_ctrl;
    localparam int DIV_LOG2 = 1;
    localparam int PWR_RST_BITS = 4;
    localparam int DEB = 8;
    localparam int HALF = 2 ** DIV_LOG2;
    localparam int RST_LEN = 2 ** PWR_RST_BITS;
`ifdef CORE_CLOCK_CTRL_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif
    logic clk50 = 1'b0, rst_n = 1'b1, run_sw = 1'b1, step_key_n = 1'b1, key_rst_n = 1'b1;
    int n_cmp = 0, n_err = 0, ref_rises = 0, hi_cnt = 0;
    logic mon_prev = 1'b0;
    core_clock_ctrl_if cif();
    core_clock_ctrl #(.DIV_LOG2(DIV_LOG2), .PWR_RST_BITS(PWR_RST_BITS), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk50(clk50), .rst_n(rst_n), .run_sw(run_sw), .step_key_n(step_key_n), .key_rst_n(key_rst_n), .bus(cif)
    );
    always #5 clk50 = ~clk50;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] exp_cc(input int n);
        return CC_EN ? 32'(n) : 32'h0;
    endfunction
    task automatic cyc(input int n);
        repeat (n) @(negedge clk50);
    endtask
    task automatic cc_check(input string tag);
        #1 check(tag, cif.cycle_count, exp_cc(ref_rises));
    endtask
    task automatic wait_rise(input string tag, output int n);
        logic p;
        p = cif.core_clock;
        n = 0;
        while (n < 40) begin
            @(negedge clk50);
            n++;
            if (cif.core_clock && !p) return;
            p = cif.core_clock;
        end
        check({tag, "_timeout"}, n, 0);
    endtask
    // reference: count core clock rises outside reset, every high phase lasts HALF cycles unless cut by reset
    always @(negedge clk50) begin
        if (cif.core_clock) hi_cnt++;
        else begin
            if (mon_prev && !cif.core_rst) check("hi_len", hi_cnt, HALF);
            hi_cnt = 0;
        end
        if (cif.core_rst) ref_rises = 0;
        else if (cif.core_clock && !mon_prev) ref_rises++;
        mon_prev = cif.core_clock;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        int n, r0, len, hi, h, is_long;
        cif.rst_req = 1'b0;
        cif.clkbreak = 1'b0;
        #2 rst_n = 1'b0;
        cyc(3);
        check("rst_core_rst", cif.core_rst, 1);
        check("rst_core_clock", cif.core_clock, 0);
        check("rst_halted", cif.halted, 0);
        check("rst_cycle_count", cif.cycle_count, 0);
        rst_n = 1'b1;
        n = 0;
        do begin @(negedge clk50); n++; end while (cif.core_rst && n < 60);
        check("por_len_in_16_to_18", 32'(n - 1 >= RST_LEN && n - 1 <= RST_LEN + 2), 1);
        wait_rise("first_rise", n);
        for (int i = 0; i < 4; i++) begin
            wait_rise("period_rise", n);
            check("period", n, 2 * HALF);
        end
        check("cc5", cif.cycle_count, exp_cc(5));
        cyc($urandom_range(3, 40));
        cc_check("cc_run");
        // breakpoint pulsed during a high phase
        wait_rise("brk_rise", n);
        cyc($urandom_range(0, HALF - 1));
        cif.clkbreak = 1'b1;
        @(negedge clk50);
        cif.clkbreak = 1'b0;
        #1 r0 = ref_rises;
        cyc(12);
        #1 check("brk_no_rise", ref_rises, r0);
        check("brk_halted", cif.halted, 1);
        check("brk_clock_low", cif.core_clock, 0);
        cc_check("brk_cc");
        // single steps: long presses step once, short glitches do nothing
        for (int k = 0; k < 4; k++) begin
            is_long = (k == 0) ? 1 : (k == 1) ? 0 : int'($urandom_range(0, 1));
            len = is_long ? int'($urandom_range(12, 20)) : int'($urandom_range(1, 5));
            #1 r0 = ref_rises;
            step_key_n = 1'b0;
            cyc(len);
            step_key_n = 1'b1;
            cyc(30);
            #1 check("step_rises", ref_rises - r0, is_long);
            check("step_halted", cif.halted, 1);
            cc_check("step_cc");
        end
        // resume from HALT on a run switch rising edge
        run_sw = 1'b0;
        cyc(5);
        check("halt_sw0", cif.halted, 1);
        run_sw = 1'b1;
        n = 0;
        do begin @(negedge clk50); n++; end while (cif.halted && n < 10);
        check("resume_within_3", 32'(n <= 3), 1);
        wait_rise("resume_rise", n);
        check("resume_first_rise", 32'(n <= 2 * HALF), 1);
        // switch off in RUN stops at a low phase
        run_sw = 1'b0;
        cyc(12);
        check("sw_halted", cif.halted, 1);
        check("sw_clock_low", cif.core_clock, 0);
        run_sw = 1'b1;
        cyc(5);
        check("sw_resumed", cif.halted, 0);
        // software reset mid-high-phase with breakpoint held through reset
        wait_rise("rr_rise", n);
        cyc($urandom_range(0, HALF - 1));
        cif.rst_req = 1'b1;
        cif.clkbreak = 1'b1;
        @(negedge clk50);
        cif.rst_req = 1'b0;
        check("rr_clock_low", cif.core_clock, 0);
        check("rr_core_rst", cif.core_rst, 1);
        check("rr_cc_clear", cif.cycle_count, 0);
        n = 1;
        while (cif.core_rst && n < 60) begin @(negedge clk50); n++; end
        cif.clkbreak = 1'b0;
        check("rr_len", n - 1, RST_LEN);
        h = 0;
        for (int i = 0; i < 24; i++) begin @(negedge clk50); h += int'(cif.halted); end
        check("rr_no_halt", h, 0);
        #1 check("rr_running", 32'(ref_rises >= 4), 1);
        cc_check("rr_cc_run");
        // reset key held for a random number of cycles
        len = $urandom_range(3, 8);
        key_rst_n = 1'b0;
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk50);
            if (i == len - 1) key_rst_n = 1'b1;
            hi += int'(cif.core_rst);
        end
        check("key_len", hi, len + RST_LEN - 1);
        cc_check("key_cc");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
